serial_disp_rx: RTL and testbench
=================================

SERIAL_DISP_RX -- requirements
Module: serial_disp_rx

Interface
REQ-001 The block SHALL have parameter FRAME_BITS, default 64, giving the number of bits in one display frame (64 = 8 digits x 8 segments; 16 = LED bank).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the flip-flop depth of each input synchronizer (minimum 2).
REQ-003 clk  input  1  system clock; the only clock in the block.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 s_clk  input  1  asynchronous serial shift clock; data is valid on its rising edge.
REQ-006 s_din  input  1  asynchronous serial data line.
REQ-007 s_pen  input  1  asynchronous parallel-load enable; a rising edge ends the frame.
REQ-008 s_clrn  input  1  asynchronous active-low frame clear.
REQ-009 par_data  output  FRAME_BITS  last frame accepted.
REQ-010 frame_valid  output  1  one-cycle pulse when par_data updates.
REQ-011 frame_err  output  1  one-cycle pulse when a latch is rejected.
REQ-012 bit_cnt  output  $clog2(FRAME_BITS+2)  bits shifted since the last frame boundary (saturating).
REQ-013 busy  output  1  high while bit_cnt is non-zero.

Function
REQ-014 s_clk, s_din, s_pen and s_clrn SHALL each pass through a SYNC_STAGES-deep synchronizer clocked by clk.
REQ-015 A rising edge SHALL be detected by comparing the synchronized value against one further registered copy.
REQ-016 s_din SHALL be sampled from its synchronized copy in the same cycle the s_clk rising edge is detected.
REQ-017 On an s_clk rising edge the shift register SHALL shift left and take s_din into bit 0, so the MSB is sent first.
REQ-018 On an s_clk rising edge bit_cnt SHALL increment, saturating at FRAME_BITS+1.
REQ-019 Shift latency SHALL be SYNC_STAGES+1 clk edges from a stable s_clk rise to the shift register and bit_cnt update.
REQ-020 On an s_pen rising edge with bit_cnt == FRAME_BITS, par_data SHALL load the shift register and frame_valid SHALL pulse on the next edge.
REQ-021 On an s_pen rising edge with bit_cnt != FRAME_BITS (short frame or overrun), par_data SHALL hold and frame_err SHALL pulse for one cycle.
REQ-022 Every s_pen rising edge, accepted or rejected, SHALL clear bit_cnt to 0.
REQ-023 On overrun the shift register SHALL keep shifting and retain the most recent FRAME_BITS bits.
REQ-024 When an s_clk rising edge and an s_pen rising edge are detected in the same cycle, the shift SHALL apply first and the latch SHALL use the shifted value and the incremented count.
REQ-025 While synchronized s_clrn is low, the shift register and bit_cnt SHALL clear every cycle.
REQ-026 While synchronized s_clrn is low, s_clk and s_pen edges SHALL be ignored, and par_data SHALL hold.
REQ-027 frame_valid and frame_err SHALL never be high in the same cycle.
REQ-028 Each pulse SHALL last exactly one clk cycle per s_pen edge.
REQ-029 The block SHALL contain a 2-state frame FSM: IDLE (bit_cnt == 0) and SHIFT.
  - IDLE -> SHIFT on an s_clk edge.
  - SHIFT -> IDLE on an s_pen edge or while s_clrn is low.
  - busy SHALL be 1 exactly in SHIFT.

Reset
REQ-030 While rst is high at a clk edge, the following SHALL be 0: par_data, shift register, bit_cnt, frame_valid, frame_err, busy, and FSM = IDLE.
REQ-031 While rst is high at a clk edge, all synchronizer and edge-detect flops SHALL be set to the idle line levels: s_clk=1, s_din=0, s_pen=0, s_clrn=1.
REQ-032 Because of REQ-031, no edge SHALL be reported in the first cycle after reset.
REQ-033 rst asserted mid-frame SHALL discard the partial frame with no frame_err.
REQ-034 rst SHALL take priority over s_clrn and all edges.

Structure
REQ-035 A shared package serial_disp_pkg SHALL hold the FSM state encoding and the idle line-level constants.
REQ-036 A sub-module sync_edge (parameters SYNC_STAGES, RESET_VAL; outputs level and rise) SHALL be instantiated once per input line.
REQ-037 The frame FSM, shift register and latch SHALL reside in serial_disp_rx.

Verification
REQ-038 Reset release, FRAME_BITS=64: shift 64'h0123_4567_89AB_CDEF MSB-first, then pulse s_pen -> par_data = 64'h0123456789ABCDEF, one frame_valid, bit_cnt = 0.
REQ-039 Short frame: 63 bits, then s_pen -> frame_err pulse, par_data unchanged from the prior frame, bit_cnt = 0.
REQ-040 Overrun: 70 bits, then s_pen -> bit_cnt saturates at 65, frame_err pulse, par_data unchanged.
REQ-041 Clear: after 20 bits drive s_clrn low for 4 cycles, then send a clean 64-bit frame -> bit_cnt = 0 during the clear, next frame accepted with correct data.
REQ-042 Coincidence: 63rd-to-64th bit s_clk rise in the same cycle as the s_pen rise -> frame accepted, bit 0 = last s_din.
REQ-043 rst mid-frame after 30 bits -> all outputs 0 next cycle, no pulses; the following full frame is accepted.

Source files
------------

// File: rtl/serial_disp_pkg.sv
// serial_disp_pkg: frame FSM encoding and idle line levels shared by the serial display receiver
package serial_disp_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam logic IDLE_S_CLK  = 1'b1;
  localparam logic IDLE_S_DIN  = 1'b0;
  localparam logic IDLE_S_PEN  = 1'b0;
  localparam logic IDLE_S_CLRN = 1'b1;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchronizer with rising-edge detect against one extra registered copy
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise
);
  logic [SYNC_STAGES-1:0] q;
  logic                   prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= {SYNC_STAGES{RESET_VAL}};
      prev <= RESET_VAL;
    end else begin
      q    <= {q[SYNC_STAGES-2:0], d};
      prev <= q[SYNC_STAGES-1];
    end
  end
  assign level = q[SYNC_STAGES-1];
  assign rise  = level & ~prev;
endmodule

// File: rtl/serial_disp_rx.sv
// serial_disp_rx: shift-register display frame receiver with latch, clear and frame checking
module serial_disp_rx
  import serial_disp_pkg::*;
#(
  parameter int FRAME_BITS  = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_clk,
  input  logic                            s_din,
  input  logic                            s_pen,
  input  logic                            s_clrn,
  output logic [FRAME_BITS-1:0]           par_data,
  output logic                            frame_valid,
  output logic                            frame_err,
  output logic [$clog2(FRAME_BITS+2)-1:0] bit_cnt,
  output logic                            busy
);
  localparam int CW = $clog2(FRAME_BITS+2);
  localparam logic [CW-1:0] CFULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CMAX  = CW'(FRAME_BITS + 1);

  logic clk_rise, din_lvl, pen_rise, clrn_lvl;
  logic unused_clk_lvl, unused_din_rise, unused_pen_lvl, unused_clrn_rise;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(IDLE_S_CLK)) u_clk (
    .clk(clk), .rst(rst), .d(s_clk), .level(unused_clk_lvl), .rise(clk_rise));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(IDLE_S_DIN)) u_din (
    .clk(clk), .rst(rst), .d(s_din), .level(din_lvl), .rise(unused_din_rise));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(IDLE_S_PEN)) u_pen (
    .clk(clk), .rst(rst), .d(s_pen), .level(unused_pen_lvl), .rise(pen_rise));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(IDLE_S_CLRN)) u_clrn (
    .clk(clk), .rst(rst), .d(s_clrn), .level(clrn_lvl), .rise(unused_clrn_rise));

  state_t                state;
  logic [FRAME_BITS-1:0] sr, sr_n;
  logic [CW-1:0]         cnt_n;
  logic                  accept;

  // a coincident shift is applied before the latch looks at the frame
  always_comb begin
    sr_n   = clk_rise ? {sr[FRAME_BITS-2:0], din_lvl} : sr;
    cnt_n  = clk_rise ? bit_cnt + CW'(bit_cnt != CMAX) : bit_cnt;
    accept = pen_rise && cnt_n == CFULL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sr          <= '0;
      par_data    <= '0;
      bit_cnt     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else if (!clrn_lvl) begin
      state       <= IDLE;
      sr          <= '0;
      bit_cnt     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= pen_rise ? IDLE : clk_rise ? SHIFT : state;
      sr          <= sr_n;
      par_data    <= accept ? sr_n : par_data;
      bit_cnt     <= pen_rise ? '0 : cnt_n;
      frame_valid <= accept;
      frame_err   <= pen_rise && !accept;
    end
  end

  assign busy = state == SHIFT;
endmodule

// File: tb/tb_serial_disp_rx.sv
// tb_serial_disp_rx: directed and randomized frames checked against a bit-list reference model
module tb_serial_disp_rx;
  logic        clk = 1'b0;
  logic        rst, s_clk, s_din, s_pen, s_clrn;
  logic [63:0] par_data;
  logic        frame_valid, frame_err, busy;
  logic [6:0]  bit_cnt;
  int          checks = 0, errors = 0;
  logic [63:0] msr, mpar;
  int          mcnt;

  serial_disp_rx #(.FRAME_BITS(64), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .s_clk(s_clk), .s_din(s_din), .s_pen(s_pen), .s_clrn(s_clrn),
    .par_data(par_data), .frame_valid(frame_valid), .frame_err(frame_err),
    .bit_cnt(bit_cnt), .busy(busy));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_bit(input logic b);
    msr  = {msr[62:0], b};
    mcnt = mcnt < 65 ? mcnt + 1 : 65;
  endtask

  task automatic send_bit(input logic b);
    s_din = b;
    s_clk = 1'b0;
    repeat (4) tick;
    s_clk = 1'b1;
    repeat (4) tick;
    model_bit(b);
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i % 64]);
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom));
  endtask

  task automatic check_cnt(input string tag);
    chk({tag, "_cnt"}, 64'(bit_cnt), 64'(mcnt));
    chk({tag, "_busy"}, 64'(busy), 64'(mcnt != 0));
  endtask

  task automatic watch_pen(input string tag);
    int fv = 0, fe = 0, both = 0;
    bit ok;
    ok = mcnt == 64;
    if (ok) mpar = msr;
    mcnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      fv += int'(frame_valid);
      fe += int'(frame_err);
      both += int'(frame_valid && frame_err);
    end
    s_pen = 1'b0;
    repeat (4) tick;
    chk({tag, "_valid_pulses"}, 64'(fv), 64'(ok));
    chk({tag, "_err_pulses"}, 64'(fe), 64'(!ok));
    chk({tag, "_overlap"}, 64'(both), 64'd0);
    chk({tag, "_par"}, par_data, mpar);
    check_cnt(tag);
  endtask

  task automatic pulse_pen(input string tag);
    s_pen = 1'b1;
    watch_pen(tag);
  endtask

  initial begin
    rst = 1'b1; s_clk = 1'b1; s_din = 1'b0; s_pen = 1'b0; s_clrn = 1'b1;
    msr = '0; mpar = '0; mcnt = 0;
    repeat (3) tick;
    chk("rst_par", par_data, 64'd0);
    chk("rst_valid", 64'(frame_valid), 64'd0);
    chk("rst_err", 64'(frame_err), 64'd0);
    check_cnt("rst");
    rst = 1'b0;
    tick;
    chk("post_rst_pulses", 64'({frame_valid, frame_err}), 64'd0);
    check_cnt("post_rst");

    send_bits(64'h0123_4567_89AB_CDEF, 64);
    check_cnt("full");
    pulse_pen("full");
    chk("full_value", par_data, 64'h0123456789ABCDEF);

    send_rand(63);
    check_cnt("short");
    pulse_pen("short");

    send_rand(70);
    chk("overrun_sat", 64'(bit_cnt), 64'd65);
    pulse_pen("overrun");

    send_rand(20);
    check_cnt("pre_clr");
    s_clrn = 1'b0;
    repeat (4) tick;
    msr = '0; mcnt = 0;
    chk("clr_cnt", 64'(bit_cnt), 64'd0);
    chk("clr_busy", 64'(busy), 64'd0);
    s_clk = 1'b0; s_pen = 1'b1;
    repeat (2) tick;
    s_clk = 1'b1; s_pen = 1'b0;
    repeat (2) tick;
    chk("clr_ignore_cnt", 64'(bit_cnt), 64'd0);
    chk("clr_ignore_par", par_data, mpar);
    s_clrn = 1'b1;
    repeat (4) tick;
    chk("clr_no_pulse", 64'({frame_valid, frame_err}), 64'd0);
    send_rand(64);
    pulse_pen("after_clr");

    send_rand(63);
    s_din = 1'($urandom);
    s_clk = 1'b0;
    repeat (4) tick;
    s_clk = 1'b1;
    s_pen = 1'b1;
    model_bit(s_din);
    watch_pen("coinc");
    chk("coinc_bit0", 64'(par_data[0]), 64'(msr[0]));

    send_rand(30);
    check_cnt("mid");
    rst = 1'b1;
    tick;
    msr = '0; mpar = '0; mcnt = 0;
    chk("mid_rst_par", par_data, 64'd0);
    chk("mid_rst_pulses", 64'({frame_valid, frame_err}), 64'd0);
    check_cnt("mid_rst");
    rst = 1'b0;
    repeat (3) tick;
    chk("mid_rst_quiet", 64'({frame_valid, frame_err}), 64'd0);
    send_rand(64);
    pulse_pen("after_rst");

    for (int f = 0; f < 12; f++) begin
      int n;
      case ($urandom_range(0, 3))
        0: n = 64;
        1: n = 63;
        2: n = 65 + int'($urandom_range(0, 6));
        default: n = int'($urandom_range(0, 80));
      endcase
      send_rand(n);
      check_cnt("rand");
      pulse_pen("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
